sdhci_int_status: RTL and testbench

SDHCI_INT_STATUS -- requirements
Module: sdhci_int_status

---
 rtl/sdhci_int_status_if.sv | 27 ++
 rtl/sdhci_int_status.sv | 119 +++++++++++
 tb/tb_sdhci_int_status.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdhci_int_status_if.sv
// Host-side register view of the SDHCI interrupt block: enables, W1C clears,
// status read-back and the interrupt line.
interface sdhci_int_status_if;
    logic [15:0] nrm_stat_en_i;
    logic [15:0] nrm_sig_en_i;
    logic [15:0] err_stat_en_i;
    logic [15:0] err_sig_en_i;
    logic [15:0] nrm_clr_i;
    logic [15:0] err_clr_i;
    logic        nrm_clr_we_i;
    logic        err_clr_we_i;
    logic [15:0] nrm_stat_o;
    logic [15:0] err_stat_o;
    logic        irq_o;

    modport master (
        output nrm_stat_en_i, nrm_sig_en_i, err_stat_en_i, err_sig_en_i,
        output nrm_clr_i, err_clr_i, nrm_clr_we_i, err_clr_we_i,
        input  nrm_stat_o, err_stat_o, irq_o
    );

    modport slave (
        input  nrm_stat_en_i, nrm_sig_en_i, err_stat_en_i, err_sig_en_i,
        input  nrm_clr_i, err_clr_i, nrm_clr_we_i, err_clr_we_i,
        output nrm_stat_o, err_stat_o, irq_o
    );
endinterface

// File: rtl/sdhci_int_status.sv
// SDHCI normal/error interrupt status registers with card-detect debounce
// and a registered level interrupt to the host.
module sdhci_int_status #(
    parameter int DebounceCycles = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_evt_i,
    input  logic                     xfer_evt_i,
    input  logic                     gap_evt_i,
    input  logic                     dma_evt_i,
    input  logic [15:0]              err_evt_i,
    input  logic                     buf_wr_en_i,
    input  logic                     buf_rd_en_i,
    input  logic                     card_int_i,
    input  logic                     card_det_raw_i,
    output logic                     card_present_o,
    sdhci_int_status_if.slave        host
);

    localparam int              CntW       = (DebounceCycles > 2) ? $clog2(DebounceCycles) : 1;
    localparam logic [CntW-1:0] CntLast    = CntW'(DebounceCycles - 2);
    localparam logic [15:0]     ErrMask    = 16'hF3FF;
    localparam logic [15:0]     NrmIrqMask = 16'h7FFF;

    logic [7:0]      r_nrm_lat;
    logic [15:0]     r_err_lat;
    logic            r_irq;
    logic            r_present;
    logic            r_raw_prev;
    logic [CntW-1:0] r_cnt;
    logic            r_wr_prev;
    logic            r_rd_prev;

    logic [7:0]      w_nrm_lat_next;
    logic [15:0]     w_err_lat_next;
    logic [7:0]      w_nrm_evt;
    logic [15:0]     w_nrm_stat;
    logic            w_irq_next;
    logic            w_pending;
    logic            w_accept;
    logic            w_ins;
    logic            w_rem;
    logic [CntW-1:0] w_cnt_next;
    logic            w_unused_ok;

    // Counter only runs while raw is stable and disagrees with the accepted level;
    // acceptance happens on the cycle the count would reach DebounceCycles-1.
    always_comb begin
        w_pending  = (card_det_raw_i == r_raw_prev) && (card_det_raw_i != r_present);
        w_accept   = w_pending && (r_cnt == CntLast);
        w_ins      = w_accept & card_det_raw_i;
        w_rem      = w_accept & ~card_det_raw_i;
        w_cnt_next = '0;
        if (w_pending && !w_accept) begin
            w_cnt_next = r_cnt + CntW'(1);
        end
    end

    assign w_nrm_evt = {w_rem, w_ins,
                        buf_rd_en_i & ~r_rd_prev, buf_wr_en_i & ~r_wr_prev,
                        dma_evt_i, gap_evt_i, xfer_evt_i, cmd_evt_i};

    // Set beats clear; a disabled status bit both drops its event and empties itself.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nrm
            assign w_nrm_lat_next[gi] = host.nrm_stat_en_i[gi] &
                (w_nrm_evt[gi] | (r_nrm_lat[gi] & ~(host.nrm_clr_we_i & host.nrm_clr_i[gi])));
        end
        for (gi = 0; gi < 16; gi++) begin : g_err
            if (ErrMask[gi]) begin : g_live
                assign w_err_lat_next[gi] = host.err_stat_en_i[gi] &
                    (err_evt_i[gi] | (r_err_lat[gi] & ~(host.err_clr_we_i & host.err_clr_i[gi])));
            end else begin : g_tied
                assign w_err_lat_next[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_nrm_stat = {|r_err_lat, 6'b0, card_int_i & host.nrm_stat_en_i[8], r_nrm_lat};
    // Errors reach the interrupt through their own signal enables, never via bit 15.
    assign w_irq_next = (|(w_nrm_stat & host.nrm_sig_en_i & NrmIrqMask)) |
                        (|(r_err_lat & host.err_sig_en_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_nrm_lat  <= '0;
            r_err_lat  <= '0;
            r_irq      <= 1'b0;
            r_present  <= 1'b0;
            r_raw_prev <= 1'b0;
            r_cnt      <= '0;
            r_wr_prev  <= 1'b0;
            r_rd_prev  <= 1'b0;
        end else begin
            r_nrm_lat  <= w_nrm_lat_next;
            r_err_lat  <= w_err_lat_next;
            r_irq      <= w_irq_next;
            r_raw_prev <= card_det_raw_i;
            r_cnt      <= w_cnt_next;
            r_wr_prev  <= buf_wr_en_i;
            r_rd_prev  <= buf_rd_en_i;
            if (w_accept) begin
                r_present <= card_det_raw_i;
            end
        end
    end

    assign host.nrm_stat_o = w_nrm_stat;
    assign host.err_stat_o = r_err_lat;
    assign host.irq_o      = r_irq;
    assign card_present_o  = r_present;

    assign w_unused_ok = ^{host.nrm_clr_i[15:8], host.err_clr_i[11:10],
                           err_evt_i[11:10], host.err_stat_en_i[11:10],
                           host.nrm_stat_en_i[15:9]};

endmodule

// File: tb/tb_sdhci_int_status.sv
// Bench for sdhci_int_status: directed vector table, multi-cycle corner
// sequences and a randomized run against a behavioural model.
module tb_sdhci_int_status;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd = 1'b0, xfer = 1'b0, gap = 1'b0, dma = 1'b0;
    logic [15:0] err_evt = '0;
    logic        buf_wr = 1'b0, buf_rd = 1'b0, card_int = 1'b0, raw = 1'b0;
    logic        card_present;

    int n_cmp = 0;
    int n_bad = 0;

    sdhci_int_status_if host_if ();

    sdhci_int_status #(.DebounceCycles(N)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .cmd_evt_i      (cmd),
        .xfer_evt_i     (xfer),
        .gap_evt_i      (gap),
        .dma_evt_i      (dma),
        .err_evt_i      (err_evt),
        .buf_wr_en_i    (buf_wr),
        .buf_rd_en_i    (buf_rd),
        .card_int_i     (card_int),
        .card_det_raw_i (raw),
        .card_present_o (card_present),
        .host           (host_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_present(input logic want, output int steps);
        steps = 0;
        while (card_present !== want && steps < 40) begin
            step();
            steps++;
        end
    endtask

    // ---------------- behavioural model (random phase) ----------------
    logic [7:0]  m_nrm;
    logic [15:0] m_err;
    logic        m_irq, m_present, m_raw_prev, m_wr_prev, m_rd_prev;
    int          m_hold;

    function automatic logic [15:0] m_nview();
        return {|m_err, 6'b0, card_int & host_if.nrm_stat_en_i[8], m_nrm};
    endfunction

    task automatic model_reset();
        m_nrm = '0; m_err = '0; m_irq = 0; m_present = 0;
        m_raw_prev = 0; m_wr_prev = 0; m_rd_prev = 0; m_hold = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [15:0] nv;
        logic [7:0]  ev;
        logic        irq_n, ins, rem;
        nv    = m_nview();
        irq_n = (|(nv & host_if.nrm_sig_en_i & 16'h7FFF)) | (|(m_err & host_if.err_sig_en_i));
        // m_hold = how many consecutive edges have seen raw at its present value
        if (raw == m_raw_prev) m_hold++;
        else m_hold = 1;
        m_raw_prev = raw;
        ins = 0; rem = 0;
        if (raw != m_present && m_hold >= N) begin
            m_present = raw;
            ins = raw;
            rem = !raw;
        end
        ev = {rem, ins, buf_rd && !m_rd_prev, buf_wr && !m_wr_prev, dma, gap, xfer, cmd};
        for (int i = 0; i < 8; i++) begin
            if (!host_if.nrm_stat_en_i[i]) m_nrm[i] = 0;
            else if (ev[i]) m_nrm[i] = 1;
            else if (host_if.nrm_clr_we_i && host_if.nrm_clr_i[i]) m_nrm[i] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 10 || i == 11 || !host_if.err_stat_en_i[i]) m_err[i] = 0;
            else if (err_evt[i]) m_err[i] = 1;
            else if (host_if.err_clr_we_i && host_if.err_clr_i[i]) m_err[i] = 0;
        end
        m_wr_prev = buf_wr;
        m_rd_prev = buf_rd;
        m_irq = irq_n;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  evt;   // {dma, gap, xfer, cmd}
        logic [15:0] err;
        logic [15:0] nclr;
        logic [15:0] eclr;
        logic [15:0] nen;
        logic [15:0] nsig;
        logic [15:0] een;
        logic [15:0] esig;
        logic [15:0] x_nrm;
        logic [15:0] x_err;
        logic        x_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] evt, logic [15:0] err, logic [15:0] nclr,
                                logic [15:0] eclr, logic [15:0] nen, logic [15:0] nsig,
                                logic [15:0] een, logic [15:0] esig,
                                logic [15:0] xn, logic [15:0] xe, logic xi);
        vec_t v;
        v.evt = evt; v.err = err; v.nclr = nclr; v.eclr = eclr;
        v.nen = nen; v.nsig = nsig; v.een = een; v.esig = esig;
        v.x_nrm = xn; v.x_err = xe; v.x_irq = xi;
        return v;
    endfunction

    task automatic idle_inputs();
        cmd = 0; xfer = 0; gap = 0; dma = 0; err_evt = '0;
        host_if.nrm_clr_we_i = 0; host_if.err_clr_we_i = 0;
        host_if.nrm_clr_i = '0; host_if.err_clr_i = '0;
    endtask

    initial begin
        int s;
        logic [15:0] NE, NS, EE, ES;
        NE = 16'h01FF; NS = 16'h0001; EE = 16'hF3FF; ES = 16'h0000;

        host_if.nrm_stat_en_i = NE; host_if.nrm_sig_en_i = NS;
        host_if.err_stat_en_i = EE; host_if.err_sig_en_i = ES;
        idle_inputs();

        // reset state
        #12;
        chk("rst_nrm", host_if.nrm_stat_o, 16'h0);
        chk("rst_err", host_if.err_stat_o, 16'h0);
        chk("rst_irq", host_if.irq_o, 1'b0);
        chk("rst_present", card_present, 1'b0);
        @(negedge clk);
        rst_ni = 1;

        //            evt   err      nclr     eclr     nen      nsig     een      esig     x_nrm    x_err    irq
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h1, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0001, 16'h0000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0001, 16'h0000, NE, NS, EE, ES, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h1, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h1, 16'h0000, 16'h0001, 16'h0000, NE, NS, EE, ES, 16'h0001, 16'h0000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0001, 16'h0000, NE, NS, EE, ES, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0004, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h8000, 16'h0004, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h8000, 16'h0004, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, 16'h0004, 16'h8000, 16'h0004, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0004, NE, NS, EE, 16'h0004, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, 16'h0004, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0C00, 16'h0000, 16'h0000, NE, NS, 16'hFFFF, ES, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h2, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0002, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h01FD, NS, EE, ES, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h4, 16'h0000, 16'h0000, 16'h0000, 16'h01FB, NS, EE, ES, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h8, 16'h0000, 16'h0000, 16'h0000, NE, 16'h0008, EE, ES, 16'h0008, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, 16'h0008, EE, ES, 16'h0008, 16'h0000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'hFFFF, 16'h0000, NE, 16'h0008, EE, ES, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h0, 16'h8000, 16'h0000, 16'h0000, NE, NS, EE, 16'h8000, 16'h8000, 16'h8000, 1'b0));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, 16'h8000, 16'h8000, 16'h8000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'hFFFF, NE, NS, EE, 16'h8000, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, NE, NS, EE, ES, 16'h0000, 16'h0000, 1'b0));

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            cmd = vecs[i].evt[0]; xfer = vecs[i].evt[1];
            gap = vecs[i].evt[2]; dma  = vecs[i].evt[3];
            err_evt = vecs[i].err;
            host_if.nrm_clr_i = vecs[i].nclr; host_if.nrm_clr_we_i = (vecs[i].nclr != 0);
            host_if.err_clr_i = vecs[i].eclr; host_if.err_clr_we_i = (vecs[i].eclr != 0);
            host_if.nrm_stat_en_i = vecs[i].nen; host_if.nrm_sig_en_i = vecs[i].nsig;
            host_if.err_stat_en_i = vecs[i].een; host_if.err_sig_en_i = vecs[i].esig;
            step();
            $display("vec %0d: nrm=%04h err=%04h irq=%0b", i,
                     host_if.nrm_stat_o, host_if.err_stat_o, host_if.irq_o);
            chk($sformatf("vec%0d_nrm", i), host_if.nrm_stat_o, vecs[i].x_nrm);
            chk($sformatf("vec%0d_err", i), host_if.err_stat_o, vecs[i].x_err);
            chk($sformatf("vec%0d_irq", i), host_if.irq_o, vecs[i].x_irq);
        end
        idle_inputs();
        host_if.nrm_stat_en_i = NE; host_if.nrm_sig_en_i = 16'h0000;
        host_if.err_stat_en_i = EE; host_if.err_sig_en_i = ES;

        // buffer read ready: one set per rising edge, clear holds while level stays high
        for (int k = 1; k <= 10; k++) begin
            buf_rd = 1;
            if (k == 3) begin host_if.nrm_clr_we_i = 1; host_if.nrm_clr_i = 16'h0020; end
            step();
            host_if.nrm_clr_we_i = 0; host_if.nrm_clr_i = '0;
            $display("bufrd cycle %0d: bit5=%0b", k, host_if.nrm_stat_o[5]);
            chk($sformatf("bufrd_c%0d", k), host_if.nrm_stat_o[5], (k < 3) ? 1'b1 : 1'b0);
        end
        buf_rd = 0; step();
        buf_rd = 1; step();
        chk("bufrd_reedge", host_if.nrm_stat_o[5], 1'b1);
        buf_rd = 0; buf_wr = 1; step();
        buf_wr = 0;
        chk("bufwr_edge", host_if.nrm_stat_o[5:4], 2'b11);
        host_if.nrm_clr_we_i = 1; host_if.nrm_clr_i = 16'h0030; step();
        idle_inputs();
        $display("buffer edges done: nrm=%04h", host_if.nrm_stat_o);

        // card-detect debounce with a glitch
        raw = 1; repeat (4) step();
        chk("deb_glitch_present", card_present, 1'b0);
        raw = 0; step();
        raw = 1;
        wait_present(1'b1, s);
        $display("insert: present after %0d cycles, nrm=%04h", s, host_if.nrm_stat_o);
        chk("deb_insert_cycles", s, N);
        chk("deb_insert_bit6", host_if.nrm_stat_o[6], 1'b1);
        host_if.nrm_clr_we_i = 1; host_if.nrm_clr_i = 16'h0040; step();
        idle_inputs();
        chk("deb_bit6_cleared", host_if.nrm_stat_o[6], 1'b0);
        repeat (12) step();
        chk("deb_bit6_once", host_if.nrm_stat_o[6], 1'b0);
        raw = 0;
        wait_present(1'b0, s);
        $display("remove: present low after %0d cycles, nrm=%04h", s, host_if.nrm_stat_o);
        chk("deb_remove_cycles", s, N);
        chk("deb_remove_bit7", host_if.nrm_stat_o[7], 1'b1);
        raw = 1; wait_present(1'b1, s);
        raw = 0; wait_present(1'b0, s);

        // asynchronous reset mid-operation
        cmd = 1; xfer = 1; step();
        idle_inputs(); host_if.nrm_sig_en_i = 16'h0001; step();
        $display("pre-reset: nrm=%04h irq=%0b", host_if.nrm_stat_o, host_if.irq_o);
        chk("prerst_nrm", host_if.nrm_stat_o, 16'h00C3);
        chk("prerst_irq", host_if.irq_o, 1'b1);
        #2 rst_ni = 0;
        #1;
        chk("async_rst_nrm", host_if.nrm_stat_o, 16'h0);
        chk("async_rst_irq", host_if.irq_o, 1'b0);
        chk("async_rst_present", card_present, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_ni = 1;
        repeat (20) step();
        $display("post-reset: nrm=%04h irq=%0b present=%0b", host_if.nrm_stat_o, host_if.irq_o, card_present);
        chk("postrst_nrm", host_if.nrm_stat_o, 16'h0);
        chk("postrst_irq", host_if.irq_o, 1'b0);
        chk("postrst_present", card_present, 1'b0);

        // card already present at reset release
        rst_ni = 0; raw = 1;
        @(negedge clk); rst_ni = 1;
        wait_present(1'b1, s);
        $display("present-at-reset: present after %0d cycles", s);
        chk("rstcard_cycles", s, N);
        chk("rstcard_bit6", host_if.nrm_stat_o[6], 1'b1);

        // reset during a partial debounce count
        raw = 0; wait_present(1'b0, s);
        raw = 1; repeat (5) step();
        rst_ni = 0; raw = 0;
        @(negedge clk); rst_ni = 1;
        repeat (20) step();
        $display("mid-debounce reset: present=%0b nrm=%04h", card_present, host_if.nrm_stat_o);
        chk("middeb_present", card_present, 1'b0);
        chk("middeb_nrm", host_if.nrm_stat_o, 16'h0);

        // randomized run against the model
        rst_ni = 0; raw = 0; buf_wr = 0; buf_rd = 0; card_int = 0;
        @(negedge clk); rst_ni = 1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            cmd  = ($urandom_range(0, 3) == 0);
            xfer = ($urandom_range(0, 3) == 0);
            gap  = ($urandom_range(0, 5) == 0);
            dma  = ($urandom_range(0, 5) == 0);
            err_evt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            if ($urandom_range(0, 2) == 0) buf_wr = ~buf_wr;
            if ($urandom_range(0, 2) == 0) buf_rd = ~buf_rd;
            if ($urandom_range(0, 3) == 0) card_int = ~card_int;
            if ($urandom_range(0, 24) == 0) raw = ~raw;
            host_if.nrm_clr_we_i = ($urandom_range(0, 3) == 0);
            host_if.nrm_clr_i    = 16'($urandom);
            host_if.err_clr_we_i = ($urandom_range(0, 3) == 0);
            host_if.err_clr_i    = 16'($urandom);
            host_if.nrm_stat_en_i = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'hFFFF;
            host_if.err_stat_en_i = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'hFFFF;
            host_if.nrm_sig_en_i  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'h0000;
            host_if.err_sig_en_i  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'h0000;
            model_edge();
            step();
            $display("rnd %0d: nrm=%04h err=%04h irq=%0b cd=%0b", c,
                     host_if.nrm_stat_o, host_if.err_stat_o, host_if.irq_o, card_present);
            chk($sformatf("rnd%0d_nrm", c), host_if.nrm_stat_o, m_nview());
            chk($sformatf("rnd%0d_err", c), host_if.err_stat_o, m_err);
            chk($sformatf("rnd%0d_irq", c), host_if.irq_o, m_irq);
            chk($sformatf("rnd%0d_present", c), card_present, m_present);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
